// File: rtl/hex_keypad_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Package     : keypad_defs
// Description : Shared types and constants for the hex keypad scanner:
//               FSM state encoding, frame-result encoding, row reset pattern,
//               and a helper that classifies one full scan frame.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_defs;

  localparam int         KEY_W     = 4;
  localparam logic [3:0] ROW_RESET = 4'b1110;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } kp_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } frame_kind_t;

  typedef struct packed {
    frame_kind_t      kind;
    logic [KEY_W-1:0] code;
  } frame_result_t;

  // pressed[4*r+c] is high when the key at row r, column c was seen down.
  function automatic frame_result_t classify_frame(input logic [15:0] pressed);
    frame_result_t res;
    logic [4:0]    n;
    res.kind = NONE;
    res.code = '0;
    n        = '0;
    for (int i = 0; i < 16; i++) begin
      if (pressed[i]) begin
        n        = n + 5'd1;
        res.code = KEY_W'(i);
      end
    end
    if (n == 5'd0)      res.kind = NONE;
    else if (n == 5'd1) res.kind = SINGLE;
    else                res.kind = MULTI;
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_keypad_scanner_sync2.sv
`default_nettype none
// ============================================================================
// Module      : keypad_sync2
// Description : 4-bit two-flop synchronizer for the asynchronous column
//               sense lines. Resets to all-ones (no key down).
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_sync2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  // Two back-to-back flops; idle level of the pulled-up lines is all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 4'b1111;
      r_sync <= 4'b1111;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/hex_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : hex_keypad_scanner
// Description : 4x4 hex keypad scanner. Drives one row low per slot, samples
//               synchronized active-low columns, debounces whole frames and
//               emits one-cycle key events plus a 4-digit hex entry register.
//               Optional auto-repeat is compiled in with KEYPAD_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_keypad_scanner
  import keypad_defs::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic [3:0]       rows,
  input  logic [3:0]       cols,
  input  logic             clr,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held,
  output logic [15:0]      num
);

  localparam int                  c_SLOT_W    = $clog2(SCAN_DIV);
  localparam int                  c_CNT_W     = $clog2(DEBOUNCE + 1);
  localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(SCAN_DIV - 1);
  localparam logic [c_CNT_W-1:0]  c_DB_DONE   = c_CNT_W'(DEBOUNCE);

  logic [3:0]          w_cols_sync;
  logic [c_SLOT_W-1:0] r_slot;
  logic [1:0]          r_row_idx;
  logic [3:0]          r_rows;
  logic [11:0]         r_frame;
  logic                w_slot_last;
  logic                w_frame_end;
  logic [15:0]         w_frame_bits;
  frame_result_t       w_res;
  logic                w_cand_hit;

  kp_state_t           r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_CNT_W-1:0]  w_cnt_inc;
  logic [KEY_W-1:0]    r_cand;
  logic [KEY_W-1:0]    r_key_code;
  logic                r_key_valid;
  logic                r_key_held;
  logic [15:0]         r_num;
  logic                w_accept;
  logic                w_repeat;
  logic                w_fire;

  keypad_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (cols),
    .q   (w_cols_sync)
  );

  assign w_slot_last  = (r_slot == c_SLOT_LAST);
  assign w_frame_end  = w_slot_last && (r_row_idx == 2'd3);
  // Row 3 is never stored: it is classified straight from the synchronizer.
  assign w_frame_bits = {~w_cols_sync, r_frame};
  assign w_res        = classify_frame(w_frame_bits);
  assign w_cand_hit   = (w_res.kind == SINGLE) && (w_res.code == r_cand);
  assign w_cnt_inc    = r_cnt + c_CNT_W'(1);
  assign w_accept     = w_frame_end && (r_state == DB_PRESS) && w_cand_hit &&
                        (w_cnt_inc == c_DB_DONE);
  assign w_fire       = w_accept || w_repeat;

  // Slot timer, row rotation and per-row column capture at each slot end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot    <= '0;
      r_row_idx <= 2'd0;
      r_rows    <= ROW_RESET;
      r_frame   <= '0;
    end else if (w_slot_last) begin
      r_slot    <= '0;
      r_row_idx <= r_row_idx + 2'd1;
      r_rows    <= {r_rows[2:0], r_rows[3]};
      case (r_row_idx)
        2'd0:    r_frame[3:0]  <= ~w_cols_sync;
        2'd1:    r_frame[7:4]  <= ~w_cols_sync;
        2'd2:    r_frame[11:8] <= ~w_cols_sync;
        default: ;
      endcase
    end else begin
      r_slot <= r_slot + c_SLOT_W'(1);
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_REP_W   = $clog2(c_REP_MAX + 1);

  logic [c_REP_W-1:0] r_rep;
  logic               r_rep_armed;
  logic [c_REP_W-1:0] w_rep_inc;
  logic [c_REP_W-1:0] w_rep_target;
  logic               w_rep_step;

  assign w_rep_inc    = r_rep + c_REP_W'(1);
  assign w_rep_target = r_rep_armed ? c_REP_W'(REPEAT_RATE) : c_REP_W'(REPEAT_DELAY);
  assign w_rep_step   = w_frame_end && (r_state == PRESSED) && w_cand_hit;
  assign w_repeat     = w_rep_step && (w_rep_inc == w_rep_target);

  // Held-frame counter: first target is the initial delay, then the rate.
  // It holds its value through DB_RELEASE and clears once back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep       <= '0;
      r_rep_armed <= 1'b0;
    end else if ((r_state == IDLE) || w_accept) begin
      r_rep       <= '0;
      r_rep_armed <= 1'b0;
    end else if (w_rep_step) begin
      if (w_repeat) begin
        r_rep       <= '0;
        r_rep_armed <= 1'b1;
      end else begin
        r_rep <= w_rep_inc;
      end
    end
  end
`else
  logic w_unused_repeat_cfg;
  assign w_unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
  assign w_repeat            = 1'b0;
`endif

  // Debounce FSM (advances only at frame end) and registered key outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cand      <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_num       <= '0;
    end else begin
      r_key_valid <= w_fire;
      if (w_fire) begin
        r_key_code <= r_cand;
        r_num      <= clr ? {12'h000, r_cand} : {r_num[11:0], r_cand};
      end else if (clr) begin
        r_num <= '0;
      end

      if (w_frame_end) begin
        case (r_state)
          IDLE: begin
            if (w_res.kind == SINGLE) begin
              r_state <= DB_PRESS;
              r_cand  <= w_res.code;
              r_cnt   <= c_CNT_W'(1);
            end
          end
          DB_PRESS: begin
            if (w_cand_hit) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == c_DB_DONE) begin
                r_state    <= PRESSED;
                r_key_held <= 1'b1;
              end
            end else begin
              r_state <= IDLE;
            end
          end
          PRESSED: begin
            // Extra keys (ghosting/rollover) are ignored while held.
            if (w_res.kind == NONE) begin
              r_state <= DB_RELEASE;
              r_cnt   <= c_CNT_W'(1);
            end
          end
          DB_RELEASE: begin
            if (w_res.kind == NONE) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == c_DB_DONE) begin
                r_state    <= IDLE;
                r_key_held <= 1'b0;
              end
            end else begin
              r_state <= PRESSED;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign rows      = r_rows;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign num       = r_num;

endmodule
`default_nettype wire

// File: tb/tb_hex_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_keypad_scanner
// Description : Self-checking bench for hex_keypad_scanner. A keypad model
//               drives the columns from the rows and a 16-bit key mask; a
//               step table plus directed sequences check events and num.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_keypad_scanner;

  localparam int FRAME = 16;

  logic        clk;
  logic        rst;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic        clr;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] num;
  logic [15:0] keys;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] keys;
    int          frames;
    logic        clr;
    int          ev;
    logic [3:0]  code;
    logic [15:0] num;
    logic        held;
  } step_t;

  step_t tbl[25];

  hex_keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE     (3),
    .REPEAT_DELAY (5),
    .REPEAT_RATE  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rows      (rows),
    .cols      (cols),
    .clr       (clr),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .num       (num)
  );

  always #5 clk = ~clk;

  // Keypad matrix model: a held key pulls its column low while its row is low.
  always_comb begin
    cols = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && keys[4*r+c]) cols[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs n frames from a frame boundary, counting key_valid pulses.
  task automatic run_frames(input int n, output int ev);
    ev = 0;
    repeat (FRAME * n) begin
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      if (key_valid) ev++;
    end
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         ev;
    logic [3:0] exp_rows [4];
    logic       exp_pulse;

    tbl[0]  = '{16'h0020, 6, 1'b0, 1, 4'h5, 16'h0005, 1'b1};
    tbl[1]  = '{16'h0000, 2, 1'b0, 0, 4'h5, 16'h0005, 1'b1};
    tbl[2]  = '{16'h0000, 1, 1'b0, 0, 4'h5, 16'h0005, 1'b0};
    tbl[3]  = '{16'h0200, 1, 1'b0, 0, 4'h5, 16'h0005, 1'b0};
    tbl[4]  = '{16'h0000, 1, 1'b0, 0, 4'h5, 16'h0005, 1'b0};
    tbl[5]  = '{16'h0200, 1, 1'b0, 0, 4'h5, 16'h0005, 1'b0};
    tbl[6]  = '{16'h0000, 1, 1'b0, 0, 4'h5, 16'h0005, 1'b0};
    tbl[7]  = '{16'h0200, 2, 1'b0, 0, 4'h5, 16'h0005, 1'b0};
    tbl[8]  = '{16'h0200, 1, 1'b0, 1, 4'h9, 16'h0059, 1'b1};
    tbl[9]  = '{16'h0000, 3, 1'b0, 0, 4'h9, 16'h0059, 1'b0};
    tbl[10] = '{16'h0002, 3, 1'b1, 1, 4'h1, 16'h0001, 1'b1};
    tbl[11] = '{16'h0000, 3, 1'b0, 0, 4'h1, 16'h0001, 1'b0};
    tbl[12] = '{16'h0004, 3, 1'b0, 1, 4'h2, 16'h0012, 1'b1};
    tbl[13] = '{16'h0000, 3, 1'b0, 0, 4'h2, 16'h0012, 1'b0};
    tbl[14] = '{16'h0008, 3, 1'b0, 1, 4'h3, 16'h0123, 1'b1};
    tbl[15] = '{16'h0000, 3, 1'b0, 0, 4'h3, 16'h0123, 1'b0};
    tbl[16] = '{16'h0010, 3, 1'b0, 1, 4'h4, 16'h1234, 1'b1};
    tbl[17] = '{16'h0000, 3, 1'b0, 0, 4'h4, 16'h1234, 1'b0};
    tbl[18] = '{16'h0020, 3, 1'b0, 1, 4'h5, 16'h2345, 1'b1};
    tbl[19] = '{16'h0000, 3, 1'b0, 0, 4'h5, 16'h2345, 1'b0};
    tbl[20] = '{16'h0000, 1, 1'b1, 0, 4'h5, 16'h0000, 1'b0};
    tbl[21] = '{16'h1008, 4, 1'b0, 0, 4'h5, 16'h0000, 1'b0};
    tbl[22] = '{16'h0008, 3, 1'b0, 1, 4'h3, 16'h0003, 1'b1};
    tbl[23] = '{16'h1008, 4, 1'b0, 0, 4'h3, 16'h0003, 1'b1};
    tbl[24] = '{16'h0000, 3, 1'b0, 0, 4'h3, 16'h0003, 1'b0};

    exp_rows[0] = 4'b1101;
    exp_rows[1] = 4'b1011;
    exp_rows[2] = 4'b0111;
    exp_rows[3] = 4'b1110;

    clk  = 1'b0;
    rst  = 1'b0;
    clr  = 1'b0;
    keys = 16'h0000;

    // Reset values, before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("reset_rows",      32'(rows),      32'h0000000e);
    chk("reset_num",       32'(num),       32'h00000000);
    chk("reset_key_valid", 32'(key_valid), 32'h00000000);
    chk("reset_key_held",  32'(key_held),  32'h00000000);
    chk("reset_key_code",  32'(key_code),  32'h00000000);

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Row rotation every 4 cycles over one idle frame.
    for (int s = 0; s < 4; s++) begin
      edges(4);
      chk($sformatf("rotate_rows_%0d", s), 32'(rows), 32'(exp_rows[s]));
    end

    // Table of frame-aligned steps.
    for (int i = 0; i < 25; i++) begin
      keys = tbl[i].keys;
      clr  = tbl[i].clr;
      run_frames(tbl[i].frames, ev);
      chk($sformatf("step%0d_events", i), 32'(ev),       32'(tbl[i].ev));
      chk($sformatf("step%0d_code", i),   32'(key_code), 32'(tbl[i].code));
      chk($sformatf("step%0d_num", i),    32'(num),      32'(tbl[i].num));
      chk($sformatf("step%0d_held", i),   32'(key_held), 32'(tbl[i].held));
    end

    // clr coinciding with an accept: the new digit survives alone, and the
    // event lands exactly one cycle after the third stable frame ends.
    keys = 16'h0080;
    run_frames(2, ev);
    chk("clracc_pre_events", 32'(ev), 32'h0);
    edges(15);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    chk("clracc_valid", 32'(key_valid), 32'h1);
    chk("clracc_code",  32'(key_code),  32'h7);
    chk("clracc_num",   32'(num),       32'h0007);
    keys = 16'h0000;
    edges(1);
    chk("clracc_pulse_width", 32'(key_valid), 32'h0);
    edges(15);
    run_frames(2, ev);
    chk("clracc_release_held", 32'(key_held), 32'h0);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat: pulses at accept, then +5, +7, +9, +11 frames.
    keys = 16'h0400;
    run_frames(3, ev);
    chk("rep_accept_events", 32'(ev), 32'h1);
    for (int f = 1; f <= 12; f++) begin
      run_frames(1, ev);
      exp_pulse = (f == 5) || (f == 7) || (f == 9) || (f == 11);
      chk($sformatf("rep_frame%0d", f), 32'(ev), 32'(exp_pulse));
    end
    chk("rep_num",  32'(num),      32'h0000aaaa);
    chk("rep_code", 32'(key_code), 32'h0000000a);
    keys = 16'h0000;
    run_frames(3, ev);
    chk("rep_release_events", 32'(ev),       32'h0);
    chk("rep_release_held",   32'(key_held), 32'h0);
`endif

    // Asynchronous reset in the middle of a scan with a key held.
    keys = 16'h0020;
    run_frames(3, ev);
    chk("midrst_pre_events", 32'(ev),       32'h1);
    chk("midrst_pre_held",   32'(key_held), 32'h1);
    edges(6);
    chk("midrst_pre_rows", 32'(rows), 32'hd);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rows",      32'(rows),      32'he);
    chk("midrst_num",       32'(num),       32'h0);
    chk("midrst_key_valid", 32'(key_valid), 32'h0);
    chk("midrst_key_held",  32'(key_held),  32'h0);
    @(negedge clk);
    rst  = 1'b0;
    keys = 16'h0000;
    edges(4);
    chk("postrst_rows", 32'(rows), 32'hd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hex_keypad_scanner.md
Name: hex_keypad_scanner

Overview:
- Scans a 4x4 hex matrix keypad by driving one row low at a time and sampling the active-low column lines.
- Debounces the sampled keys and emits a single-cycle key event with a 4-bit hex code.
- Keeps a 16-bit shift register of entered digits, formatted as four hex nibbles, to feed the board's multiplexed 7-segment display driver.
- It is the input-side counterpart of the display scanner in the serial transceiver board top.

Parameters:
- SCAN_DIV, 1000: clk cycles per row slot. Must be >= 4.
- DEBOUNCE, 4: consecutive identical full-scan frames needed to accept a press or release. Must be >= 2.
- REPEAT_DELAY, 50: frames held before the first auto-repeat. Used only with KEYPAD_REPEAT_EN.
- REPEAT_RATE, 10: frames between subsequent auto-repeats. Used only with KEYPAD_REPEAT_EN.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- rows  out  4  row drive, active-low, exactly one bit low at a time.
- cols  in  4  column sense, active-low, pulled up externally, asynchronous to clk.
- clr  in  1  synchronous clear of num.
- key_code  out  4  code of the last accepted key.
- key_valid  out  1  one-cycle pulse per accepted key event.
- key_held  out  1  level, high while an accepted key is still down.
- num  out  16  last four keys entered, newest in num[3:0].

Behaviour:
- Reset values: rows=4'b1110, key_code=0, key_valid=0, key_held=0, num=0. All internal counters are 0 and the state is IDLE. Reset mid-frame abandons the frame and any debounce in progress.
- cols pass through a 2-flop synchronizer before any use.
- Row slot counter counts 0..SCAN_DIV-1.
  - On the last cycle of a slot, the synchronized cols value is captured for the current row.
  - rows then rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- One frame is 4 slots (4*SCAN_DIV cycles). The frame ends at the capture of row 3 (rows=0111).
- Key mapping: a low on cols[c] while rows[r] is low is code 4*r+c, giving 0x0..0xF.
- Frame result is one of:
  - NONE: no low bits in any row.
  - SINGLE(code): exactly one low bit across all 16 positions.
  - MULTI: two or more low bits.
- The FSM updates only at frame end:
  - IDLE: SINGLE -> DB_PRESS, cand=code, cnt=1. Anything else -> stay in IDLE.
  - DB_PRESS:
    - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE -> PRESSED and fire the accept actions below.
    - NONE, MULTI, or a different code -> IDLE.
  - PRESSED: NONE -> DB_RELEASE, cnt=1. SINGLE(any) or MULTI -> stay; ghosting and rollover are ignored.
  - DB_RELEASE:
    - NONE: cnt+1. When cnt reaches DEBOUNCE -> IDLE.
    - Anything else -> PRESSED, with no new event.
- Accept actions, registered on the cycle after the frame-end capture:
  - key_valid=1 for exactly one cycle.
  - key_code=cand.
  - num <= {num[11:0], cand}.
- key_held=1 while the state is PRESSED or DB_RELEASE.
- clr zeroes num on the next cycle. If clr and an accept occur in the same cycle, num={12'h000, cand}.
- Press-to-event latency, measured from the stable synchronized column: at most (DEBOUNCE+1) frames + 1 cycle.
- Frame counter and slot counter wrap freely; no overflow stalls the scan.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In PRESSED with the frame result equal to SINGLE(cand), a frame counter runs.
  - After REPEAT_DELAY frames, and then every REPEAT_RATE frames, the accept actions repeat: key_valid pulse and num shift.
  - The counter resets on leaving PRESSED.
  - DB_RELEASE freezes the counter, and it resumes on return to PRESSED.
- Undefined: exactly one event per press. The repeat counter and the REPEAT_* logic are absent.

Decomposition:
- Shared package keypad_defs holds:
  - FSM state encoding: IDLE, DB_PRESS, PRESSED, DB_RELEASE.
  - Frame result encoding: NONE, SINGLE, MULTI.
  - ROW_RESET=4'b1110.
  - Key code width 4.
- One sub-module: keypad_sync2, a 4-bit two-flop synchronizer with async active-high reset to 4'b1111.

Test Plan (SCAN_DIV=4, DEBOUNCE=3, frame = 16 cycles):
- Reset: assert rst mid-scan -> rows=1110, num=0, key_valid=0 immediately, without waiting for a clk edge. After release, rows rotates every 4 cycles.
- Clean press: model key 0x5 (row1, col1) held for 6 frames -> exactly one key_valid, key_code=0x5, num=0x0005, key_held high until 3 NONE frames after release.
- Bounce: toggle key 0x9 every frame for 4 frames, then hold steady -> no event during the toggling. One event is emitted after 3 stable frames.
- Sequence 1,2,3,4,5 then clr: num reads 0x0001, 0x0012, 0x0123, 0x1234, then 0x2345. After clr, num=0x0000.
- Multi-key: hold 0x3 and 0xC from IDLE -> no event. Press 0x3 alone until accepted, then add 0xC -> still a single event and key_held stays 1.
- With KEYPAD_REPEAT_EN (REPEAT_DELAY=5, REPEAT_RATE=2): hold 0xA for 12 frames after accept -> key_valid pulses at accept, +5, +7, +9, +11 frames.
